// File: rtl/ws2812_frame_sched_pkg.sv
// Shared types and constants for the WS2812B frame scheduler.
package ws2812_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT_SER,
    LATCH
  } sched_state_t;

  localparam int COLOR_W              = 24;
  localparam int ORIENT_W             = 32;
  localparam int TIMER_W              = 11;
  localparam int DEFAULT_LATCH_CYCLES = 2000;
  localparam int DEFAULT_SER_TIMEOUT  = 2047;

endpackage

// File: rtl/ws2812_frame_sched_if.sv
// Pixel lookup and serializer handshake between the scheduler (master) and the datapath (slave).
interface ws2812_frame_sched_if
  import ws2812_pkg::*;
#(
  parameter int PIX_W = 6
);

  logic [PIX_W-1:0]   pix_index;
  logic [COLOR_W-1:0] pix_color;
  logic               ser_load;
  logic [COLOR_W-1:0] ser_data;
  logic               ser_done;

  modport master (
    output pix_index, ser_load, ser_data,
    input  pix_color, ser_done
  );

  modport slave (
    input  pix_index, ser_load, ser_data,
    output pix_color, ser_done
  );

endinterface

// File: rtl/ws2812_frame_sched_timer.sv
// Loadable 11-bit down-counter shared by the lookup wait, serializer timeout and latch gap.
module ws2812_cycle_timer
  import ws2812_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_value_i,
  output logic               zero_o,
  output logic               one_o
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Load wins over counting; the counter parks at zero until reloaded.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign one_o  = (count_q == TIMER_W'(1));

endmodule

// File: rtl/ws2812_frame_sched.sv
// WS2812B frame scheduler: fetches each pixel colour, hands it to the serializer, then holds the latch gap.
// Define WS_AUTO_REFRESH_EN to start the next frame straight after every latch gap (frame_req ignored).
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int NUM_PIXELS   = 64,
  parameter int LOOKUP_LAT   = 1,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  parameter int SER_TIMEOUT  = DEFAULT_SER_TIMEOUT,
  parameter int PIX_W        = $clog2(NUM_PIXELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_req,
  input  logic [ORIENT_W-1:0] orient_in,
  input  logic                orient_valid,
  output logic [ORIENT_W-1:0] orient_active,
  output logic                busy,
  output logic                frame_done,
  output logic                err_timeout,
  ws2812_frame_sched_if.master pix_bus
);

`ifdef WS_AUTO_REFRESH_EN
  localparam bit AUTO_REFRESH = 1'b1;
`else
  localparam bit AUTO_REFRESH = 1'b0;
`endif

  localparam logic [PIX_W-1:0]   LAST_PIX   = PIX_W'(NUM_PIXELS - 1);
  localparam logic [TIMER_W-1:0] FETCH_WAIT = TIMER_W'(LOOKUP_LAT);
  localparam logic [TIMER_W-1:0] SER_WAIT   = TIMER_W'(SER_TIMEOUT);
  localparam logic [TIMER_W-1:0] LATCH_WAIT = TIMER_W'(LATCH_CYCLES - 1);
  localparam bit                 LATCH_ONE  = (LATCH_CYCLES <= 1);

  sched_state_t        state_q;
  logic [PIX_W-1:0]    pix_index_q;
  logic [COLOR_W-1:0]  ser_data_q;
  logic                ser_load_q;
  logic                busy_q;
  logic                frame_done_q;
  logic                err_timeout_q;
  logic                pend_f_q;
  logic                pend_o_q;
  logic [ORIENT_W-1:0] orient_pending_q;
  logic [ORIENT_W-1:0] orient_active_q;

  logic               idle_start;
  logic               frame_start;
  logic               last_pix;
  logic               ser_timeout;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;
  logic               timer_one;

  ws2812_cycle_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .load_i       (timer_load),
    .load_value_i (timer_value),
    .zero_o       (timer_zero),
    .one_o        (timer_one)
  );

  // The serializer timeout counts from the ser_load cycle and aborts on the edge the counter hits zero.
  always_comb begin
    idle_start  = AUTO_REFRESH || frame_req || pend_f_q;
    last_pix    = (pix_index_q == LAST_PIX);
    ser_timeout = timer_one || timer_zero;
    frame_start = ((state_q == IDLE) && idle_start) ||
                  ((state_q == LATCH) && timer_zero && AUTO_REFRESH);
    timer_load  = 1'b0;
    timer_value = FETCH_WAIT;
    case (state_q)
      IDLE:     timer_load = idle_start;
      FETCH: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = SER_WAIT;
        end
      end
      WAIT_SER: begin
        if (pix_bus.ser_done) begin
          timer_load  = 1'b1;
          timer_value = last_pix ? LATCH_WAIT : FETCH_WAIT;
        end else if (ser_timeout) begin
          timer_load  = 1'b1;
          timer_value = LATCH_WAIT;
        end
      end
      LATCH:    timer_load = timer_zero && AUTO_REFRESH;
      default:  timer_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pix_index_q   <= '0;
      ser_data_q    <= '0;
      ser_load_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      pend_f_q      <= 1'b0;
    end else begin
      ser_load_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (!AUTO_REFRESH && frame_req && (state_q != IDLE)) begin
        pend_f_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          pix_index_q <= '0;
          if (idle_start) begin
            state_q  <= FETCH;
            pend_f_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        FETCH: begin
          if (timer_zero) begin
            ser_data_q <= pix_bus.pix_color;
            ser_load_q <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: state_q <= WAIT_SER;
        WAIT_SER: begin
          if (pix_bus.ser_done) begin
            if (last_pix) begin
              state_q      <= LATCH;
              frame_done_q <= LATCH_ONE;
            end else begin
              pix_index_q <= pix_index_q + 1'b1;
              state_q     <= FETCH;
            end
          end else if (ser_timeout) begin
            err_timeout_q <= 1'b1;
            state_q       <= LATCH;
            frame_done_q  <= LATCH_ONE;
          end
        end
        // frame_done is raised one cycle early so it lands on the final latch cycle.
        LATCH: begin
          frame_done_q <= timer_one;
          if (timer_zero) begin
            if (AUTO_REFRESH) begin
              pix_index_q <= '0;
              state_q     <= FETCH;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A same-cycle orient_valid bypasses the pending copy at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_o_q         <= 1'b0;
      orient_pending_q <= '0;
      orient_active_q  <= '0;
    end else begin
      if (orient_valid) begin
        orient_pending_q <= orient_in;
        pend_o_q         <= 1'b1;
      end
      if (frame_start) begin
        if (orient_valid) begin
          orient_active_q <= orient_in;
          pend_o_q        <= 1'b0;
        end else if (pend_o_q) begin
          orient_active_q <= orient_pending_q;
          pend_o_q        <= 1'b0;
        end
      end
    end
  end

  assign orient_active     = orient_active_q;
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;
  assign err_timeout       = err_timeout_q;
  assign pix_bus.pix_index = pix_index_q;
  assign pix_bus.ser_load  = ser_load_q;
  assign pix_bus.ser_data  = ser_data_q;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed bench for ws2812_frame_sched: 4 pixels, latch gap 20, serializer timeout 50, serializer done after 10 cycles.
module tb_ws2812_frame_sched;
  import ws2812_pkg::*;

  localparam int NPIX  = 4;
  localparam int SLAT  = 10;
  localparam int FRAME = 72;

  logic        clk;
  logic        reset;
  logic        frame_req;
  logic [31:0] orient_in;
  logic        orient_valid;
  logic [31:0] orient_active;
  logic        busy;
  logic        frame_done;
  logic        err_timeout;

  ws2812_frame_sched_if #(.PIX_W(2)) bus ();

  ws2812_frame_sched #(
    .NUM_PIXELS   (NPIX),
    .LOOKUP_LAT   (1),
    .LATCH_CYCLES (20),
    .SER_TIMEOUT  (50),
    .PIX_W        (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_req     (frame_req),
    .orient_in     (orient_in),
    .orient_valid  (orient_valid),
    .orient_active (orient_active),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_timeout   (err_timeout),
    .pix_bus       (bus)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          ser_en = 1'b1;
  int          scnt = 0;
  int          sdone_last = -1;
  logic [23:0] load_data[$];
  int          load_cyc[$];
  int          done_cyc[$];
  int          busy_fall_cyc = -1;
  int          err_rise_cyc = -1;
  logic        prev_busy = 1'b0;
  logic        prev_err = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Colour lookup returns idx*0x010101, available well within one cycle.
  assign bus.pix_color = {3{8'(bus.pix_index)}};

  // Serializer model: ser_done pulses SLAT cycles after each captured ser_load.
  initial begin
    bus.ser_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        scnt = 0;
        bus.ser_done = 1'b0;
      end else begin
        bus.ser_done = 1'b0;
        if (scnt > 0) begin
          scnt--;
          if (scnt == 0) begin
            bus.ser_done = 1'b1;
            sdone_last = cyc;
          end
        end
        if (bus.ser_load && ser_en) scnt = SLAT;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.ser_load) begin
        load_data.push_back(bus.ser_data);
        load_cyc.push_back(cyc);
      end
      if (frame_done) done_cyc.push_back(cyc);
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      if (!prev_err && err_timeout) err_rise_cyc = cyc;
      prev_busy = busy;
      prev_err  = err_timeout;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_mon();
    load_data.delete();
    load_cyc.delete();
    done_cyc.delete();
    busy_fall_cyc = -1;
    err_rise_cyc  = -1;
  endtask

  task automatic pulse_req(output int t);
    frame_req = 1'b1;
    t = cyc;
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  task automatic go_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done(input int n, input int bound, output bit ok);
    int k = 0;
    while (done_cyc.size() < n && k < bound) begin
      @(negedge clk);
      #1;
      k++;
    end
    ok = (done_cyc.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({orient_active, bus.pix_index, bus.ser_data, bus.ser_load, busy, frame_done, err_timeout} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got oa=%h idx=%h data=%h ld=%b busy=%b fd=%b err=%b expected all zero",
               orient_active, bus.pix_index, bus.ser_data, bus.ser_load, busy, frame_done, err_timeout);
    end
    total++;
    if (dut.state_q !== IDLE) begin
      bad++;
      $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
    end
    clear_mon();
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int t0;
    bit ok;
    @(negedge clk);
    clear_mon();
    pulse_req(t0);
    total++;
    if (busy !== 1'b1 || bus.pix_index !== 2'd0) begin
      bad++;
      $display("[TB] FAIL single_start: got busy=%b idx=%0d expected busy=1 idx=0", busy, bus.pix_index);
    end
    wait_done(1, 300, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL single_done_wait: got no frame_done expected one within 300 cycles");
    end
    total++;
    if (load_cyc.size() != NPIX) begin
      bad++;
      $display("[TB] FAIL single_load_count: got %0d expected %0d", load_cyc.size(), NPIX);
    end
    for (int k = 0; k < NPIX && k < load_cyc.size(); k++) begin
      total++;
      if (load_data[k] !== 24'(k * 24'h010101)) begin
        bad++;
        $display("[TB] FAIL single_data%0d: got %h expected %h", k, load_data[k], 24'(k * 24'h010101));
      end
      total++;
      if (load_cyc[k] - t0 != 3 + k * (SLAT + 3)) begin
        bad++;
        $display("[TB] FAIL single_load_time%0d: got %0d expected %0d", k, load_cyc[k] - t0, 3 + k * (SLAT + 3));
      end
    end
    if (ok) begin
      total++;
      if (done_cyc[0] - sdone_last != 20) begin
        bad++;
        $display("[TB] FAIL single_latch_gap: got %0d expected 20", done_cyc[0] - sdone_last);
      end
      total++;
      if (done_cyc[0] - t0 != FRAME) begin
        bad++;
        $display("[TB] FAIL single_frame_len: got %0d expected %0d", done_cyc[0] - t0, FRAME);
      end
    end
    repeat (10) @(negedge clk);
    #1;
    total++;
    if (ok && busy_fall_cyc != done_cyc[0] + 1) begin
      bad++;
      $display("[TB] FAIL single_busy_drop: got cycle %0d expected %0d", busy_fall_cyc, done_cyc[0] + 1);
    end
    total++;
    if (done_cyc.size() != 1) begin
      bad++;
      $display("[TB] FAIL single_done_count: got %0d expected 1", done_cyc.size());
    end
  endtask

  task automatic test_shadow();
    int t0;
    bit ok;
    @(negedge clk);
    orient_in = 32'h0000_0ABC;
    orient_valid = 1'b1;
    @(negedge clk);
    orient_valid = 1'b0;
    orient_in = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    total++;
    if (orient_active !== 32'h0) begin
      bad++;
      $display("[TB] FAIL shadow_idle_hold: got %h expected 00000000", orient_active);
    end
    clear_mon();
    pulse_req(t0);
    total++;
    if (orient_active !== 32'h0000_0ABC) begin
      bad++;
      $display("[TB] FAIL shadow_frame_start: got %h expected 00000abc", orient_active);
    end
    go_until(t0 + 20);
    orient_in = 32'h0123_4567;
    orient_valid = 1'b1;
    @(negedge clk);
    orient_valid = 1'b0;
    go_until(t0 + 40);
    total++;
    if (orient_active !== 32'h0000_0ABC) begin
      bad++;
      $display("[TB] FAIL shadow_mid_frame: got %h expected 00000abc", orient_active);
    end
    wait_done(1, 300, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok || orient_active !== 32'h0000_0ABC) begin
      bad++;
      $display("[TB] FAIL shadow_after_frame: got %h done=%b expected 00000abc done=1", orient_active, ok);
    end
    clear_mon();
    pulse_req(t0);
    total++;
    if (orient_active !== 32'h0123_4567) begin
      bad++;
      $display("[TB] FAIL shadow_next_frame: got %h expected 01234567", orient_active);
    end
    wait_done(1, 300, ok);
    @(negedge clk);
    orient_in = 32'h1111_1111;
    orient_valid = 1'b1;
    @(negedge clk);
    orient_in = 32'h5555_AAAA;
    clear_mon();
    pulse_req(t0);
    orient_valid = 1'b0;
    total++;
    if (orient_active !== 32'h5555_AAAA) begin
      bad++;
      $display("[TB] FAIL shadow_bypass: got %h expected 5555aaaa", orient_active);
    end
    wait_done(1, 300, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL shadow_bypass_done: got no frame_done expected one");
    end
  endtask

  task automatic test_queued();
    int t0;
    int tx;
    bit ok;
    @(negedge clk);
    clear_mon();
    pulse_req(t0);
    go_until(t0 + 10);
    pulse_req(tx);
    go_until(t0 + 30);
    pulse_req(tx);
    go_until(t0 + 60);
    pulse_req(tx);
    wait_done(2, 400, ok);
    repeat (150) @(negedge clk);
    #1;
    total++;
    if (done_cyc.size() != 2) begin
      bad++;
      $display("[TB] FAIL queued_done_count: got %0d expected 2", done_cyc.size());
    end
    total++;
    if (load_cyc.size() != 2 * NPIX) begin
      bad++;
      $display("[TB] FAIL queued_load_count: got %0d expected %0d", load_cyc.size(), 2 * NPIX);
    end
    total++;
    if (!ok || done_cyc[1] - t0 != 2 * FRAME + 1) begin
      bad++;
      $display("[TB] FAIL queued_second_end: got %0d expected %0d", ok ? done_cyc[1] - t0 : -1, 2 * FRAME + 1);
    end
  endtask

  task automatic test_timeout();
    int t0;
    bit ok;
    @(negedge clk);
    ser_en = 1'b0;
    clear_mon();
    pulse_req(t0);
    wait_done(1, 300, ok);
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (load_cyc.size() != 1) begin
      bad++;
      $display("[TB] FAIL timeout_load_count: got %0d expected 1", load_cyc.size());
    end
    total++;
    if (load_cyc.size() < 1 || err_rise_cyc - load_cyc[0] != 50) begin
      bad++;
      $display("[TB] FAIL timeout_err_time: got %0d expected 50", load_cyc.size() < 1 ? -1 : err_rise_cyc - load_cyc[0]);
    end
    total++;
    if (!ok || done_cyc[0] - err_rise_cyc != 19 || done_cyc[0] - t0 != FRAME) begin
      bad++;
      $display("[TB] FAIL timeout_latch: got done=%0d err=%0d rel t0 expected done=%0d err=53",
               ok ? done_cyc[0] - t0 : -1, err_rise_cyc - t0, FRAME);
    end
    repeat (30) @(negedge clk);
    total++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_sticky_idle: got err=%b busy=%b expected err=1 busy=0", err_timeout, busy);
    end
    ser_en = 1'b1;
    clear_mon();
    pulse_req(t0);
    wait_done(1, 300, ok);
    total++;
    if (!ok || err_timeout !== 1'b1 || load_cyc.size() != NPIX) begin
      bad++;
      $display("[TB] FAIL timeout_sticky_frame: got err=%b loads=%0d done=%b expected err=1 loads=%0d done=1",
               err_timeout, load_cyc.size(), ok, NPIX);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (err_timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL timeout_reset_clear: got %b expected 0", err_timeout);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int t0;
    bit ok;
    @(negedge clk);
    clear_mon();
    pulse_req(t0);
    go_until(t0 + 20);
    total++;
    if (dut.state_q !== WAIT_SER || bus.pix_index !== 2'd1) begin
      bad++;
      $display("[TB] FAIL midreset_precond: got state=%0d idx=%0d expected state=%0d idx=1",
               dut.state_q, bus.pix_index, WAIT_SER);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({orient_active, bus.pix_index, bus.ser_data, bus.ser_load, busy, frame_done, err_timeout} !== '0
        || dut.state_q !== IDLE) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got oa=%h idx=%h data=%h ld=%b busy=%b fd=%b err=%b st=%0d expected zero/IDLE",
               orient_active, bus.pix_index, bus.ser_data, bus.ser_load, busy, frame_done, err_timeout, dut.state_q);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    pulse_req(t0);
    total++;
    if (bus.pix_index !== 2'd0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midreset_restart: got idx=%0d busy=%b expected idx=0 busy=1", bus.pix_index, busy);
    end
    wait_done(1, 300, ok);
    total++;
    if (!ok || load_cyc.size() != NPIX || load_data[0] !== 24'h0 || load_cyc[0] - t0 != 3) begin
      bad++;
      $display("[TB] FAIL midreset_frame: got done=%b loads=%0d expected done=1 loads=%0d first data 000000 at +3",
               ok, load_cyc.size(), NPIX);
    end
  endtask

`ifdef WS_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    bit ok;
    wait_done(3, 600, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL auto_done_count: got %0d expected 3", done_cyc.size());
    end
    for (int k = 1; k < 3 && k < done_cyc.size(); k++) begin
      total++;
      if (done_cyc[k] - done_cyc[k-1] != FRAME) begin
        bad++;
        $display("[TB] FAIL auto_period%0d: got %0d expected %0d", k, done_cyc[k] - done_cyc[k-1], FRAME);
      end
    end
    total++;
    if (load_cyc.size() != 3 * NPIX) begin
      bad++;
      $display("[TB] FAIL auto_load_count: got %0d expected %0d", load_cyc.size(), 3 * NPIX);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL auto_busy: got %b expected 1", busy);
    end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    frame_req    = 1'b0;
    orient_in    = 32'h0;
    orient_valid = 1'b0;
    ser_en       = 1'b1;
    $display("[TB] starting");
    test_reset();
`ifdef WS_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_single_frame();
    test_shadow();
    test_queued();
    test_timeout();
    test_reset_mid_frame();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
